// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel synchroniser, debouncer and press/release/long-press
// event generator for the front-panel buttons.
// Optional feature: define AUTOREPEAT_EN to add the auto-repeat counter in the LONG state;
// without it repeat_pulse is tied to 0 and no repeat logic exists.
module btn_conditioner #(
    parameter int unsigned NUM_BTN      = 5,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned LONG_CYC     = 1000,
    parameter int unsigned REPEAT_CYC   = 200,
    parameter bit          ACTIVE_HIGH  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse,
    output logic               any_press
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned HoldW = $clog2(LONG_CYC + 1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYC - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYC - 1);
    localparam logic [HoldW-1:0] HoldSat  = HoldW'(LONG_CYC);

    typedef enum logic [1:0] {StIdle, StPressed, StLong} state_e;

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] r_sync1, r_sync2;
    logic [DbW-1:0]     r_db_cnt [NUM_BTN];
    logic [DbW-1:0]     w_db_cnt [NUM_BTN];
    logic [HoldW-1:0]   r_hold   [NUM_BTN];
    logic [HoldW-1:0]   w_hold   [NUM_BTN];
    state_e             r_state  [NUM_BTN];
    state_e             w_state  [NUM_BTN];
    logic [NUM_BTN-1:0] r_level, w_level;
    logic [NUM_BTN-1:0] w_press_ev, w_rel_ev, w_long_ev;
    logic [NUM_BTN-1:0] r_press, r_rel, r_long;

    // Normalise polarity so 1 always means pressed from here on.
    assign w_raw = ACTIVE_HIGH ? btn_raw : ~btn_raw;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce and hold-state next-state logic, one iteration per channel.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_level[i]    = r_level[i];
            w_db_cnt[i]   = r_db_cnt[i];
            w_press_ev[i] = 1'b0;
            w_rel_ev[i]   = 1'b0;
            w_long_ev[i]  = 1'b0;
            w_state[i]    = r_state[i];
            w_hold[i]     = r_hold[i];

            if (r_sync2[i] != r_level[i]) begin
                if (r_db_cnt[i] == DbLast) begin
                    w_level[i]    = r_sync2[i];
                    w_db_cnt[i]   = '0;
                    w_press_ev[i] = r_sync2[i];
                    w_rel_ev[i]   = ~r_sync2[i];
                end else begin
                    w_db_cnt[i] = r_db_cnt[i] + 1'b1;
                end
            end else begin
                w_db_cnt[i] = '0;
            end

            case (r_state[i])
                StIdle: begin
                    if (w_press_ev[i]) begin
                        w_state[i] = StPressed;
                        w_hold[i]  = '0;
                    end
                end
                StPressed: begin
                    // Release takes priority over a long-press firing in the same cycle.
                    if (w_rel_ev[i]) begin
                        w_state[i] = StIdle;
                        w_hold[i]  = '0;
                    end else if (r_hold[i] == HoldLast) begin
                        w_state[i]   = StLong;
                        w_hold[i]    = HoldSat;
                        w_long_ev[i] = 1'b1;
                    end else begin
                        w_hold[i] = r_hold[i] + 1'b1;
                    end
                end
                StLong: begin
                    if (w_rel_ev[i]) begin
                        w_state[i] = StIdle;
                        w_hold[i]  = '0;
                    end
                end
                default: begin
                    w_state[i] = StIdle;
                    w_hold[i]  = '0;
                end
            endcase
        end
    end

    // Per-channel state, counters and registered event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_press <= '0;
            r_rel   <= '0;
            r_long  <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_db_cnt[i] <= '0;
                r_hold[i]   <= '0;
                r_state[i]  <= StIdle;
            end
        end else begin
            r_level <= w_level;
            r_press <= w_press_ev;
            r_rel   <= w_rel_ev;
            r_long  <= w_long_ev;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_db_cnt[i] <= w_db_cnt[i];
                r_hold[i]   <= w_hold[i];
                r_state[i]  <= w_state[i];
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned RptW = $clog2(REPEAT_CYC + 1);
    localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_CYC - 1);

    logic [RptW-1:0]    r_rpt [NUM_BTN];
    logic [RptW-1:0]    w_rpt [NUM_BTN];
    logic [NUM_BTN-1:0] w_rpt_ev, r_rpt_pulse;

    // Repeat counter runs only while in LONG; it is zero on entry, so the first repeat
    // lands REPEAT_CYC cycles after long_pulse.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_rpt[i]    = '0;
            w_rpt_ev[i] = 1'b0;
            if (r_state[i] == StLong && !w_rel_ev[i]) begin
                if (r_rpt[i] == RptLast) begin
                    w_rpt_ev[i] = 1'b1;
                end else begin
                    w_rpt[i] = r_rpt[i] + 1'b1;
                end
            end
        end
    end

    // Repeat counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_pulse <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_rpt[i] <= '0;
            end
        end else begin
            r_rpt_pulse <= w_rpt_ev;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_rpt[i] <= w_rpt[i];
            end
        end
    end

    assign repeat_pulse = r_rpt_pulse;
`else
    assign repeat_pulse = '0;
`endif

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_rel;
    assign long_pulse    = r_long;
    assign any_press     = |r_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner (DEBOUNCE_CYC=4, LONG_CYC=20,
// REPEAT_CYC=5, NUM_BTN=2). Repeat expectations follow AUTOREPEAT_EN.
module tb_btn_conditioner;

    localparam int unsigned NB = 2;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic [NB-1:0] long_pulse;
    logic [NB-1:0] repeat_pulse;
    logic          any_press;

    btn_conditioner #(
        .NUM_BTN     (NB),
        .DEBOUNCE_CYC(4),
        .LONG_CYC    (20),
        .REPEAT_CYC  (5),
        .ACTIVE_HIGH (1'b1)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .any_press    (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Event log since the last clear_log, indexed by channel; cyc counts edges.
    int cyc;
    int n_press [NB];
    int t_press [NB];
    int n_rel   [NB];
    int t_rel   [NB];
    int n_long  [NB];
    int t_long  [NB];
    int n_rpt   [NB];
    int t_rpt   [NB];
    int t_rpt1  [NB];
    int n_lvl   [NB];
    logic [NB-1:0] prev_lvl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0;
        for (int c = 0; c < NB; c++) begin
            n_press[c] = 0; t_press[c] = -1;
            n_rel[c]   = 0; t_rel[c]   = -1;
            n_long[c]  = 0; t_long[c]  = -1;
            n_rpt[c]   = 0; t_rpt[c]   = -1; t_rpt1[c] = -1;
            n_lvl[c]   = 0;
        end
        prev_lvl = btn_level;
    endtask

    // Advance one edge and log output events 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NB; c++) begin
            if (press_pulse[c])   begin n_press[c]++; t_press[c] = cyc; end
            if (release_pulse[c]) begin n_rel[c]++;   t_rel[c]   = cyc; end
            if (long_pulse[c])    begin n_long[c]++;  t_long[c]  = cyc; end
            if (repeat_pulse[c]) begin
                if (n_rpt[c] == 0) t_rpt1[c] = cyc;
                n_rpt[c]++;
                t_rpt[c] = cyc;
            end
            if (btn_level[c] != prev_lvl[c]) n_lvl[c]++;
        end
        prev_lvl = btn_level;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        clear_log();
        repeat (3) tick();
        check("reset_outputs", {btn_level, press_pulse, release_pulse, long_pulse,
                                repeat_pulse, any_press}, 0);

        // Both pins held through reset release: press on both at edge 6.
        rst_n = 1'b1;
        clear_log();
        tick_to(5);
        check("rst_rel_e5_press", press_pulse, 2'b00);
        check("rst_rel_e5_level", btn_level, 2'b00);
        tick_to(6);
        check("rst_rel_e6_press", press_pulse, 2'b11);
        check("rst_rel_e6_level", btn_level, 2'b11);
        check("rst_rel_e6_any", any_press, 1'b1);
        tick_to(7);
        check("rst_rel_e7_press", press_pulse, 2'b00);
        check("rst_rel_e7_any", any_press, 1'b0);
        btn_raw = 2'b00;
        tick_to(15);
        check("both_rel_t0", t_rel[0], 13);
        check("both_rel_t1", t_rel[1], 13);
        check("both_no_long", n_long[0] + n_long[1], 0);

        // Bounce on ch0: 1,0,1,0 at 2-cycle widths, then held.
        clear_log();
        btn_raw[0] = 1'b1; tick_to(2);
        btn_raw[0] = 1'b0; tick_to(4);
        btn_raw[0] = 1'b1; tick_to(6);
        btn_raw[0] = 1'b0; tick_to(8);
        btn_raw[0] = 1'b1; tick_to(20);
        check("bounce_n_press", n_press[0], 1);
        check("bounce_t_press", t_press[0], 14);
        check("bounce_lvl_chg", n_lvl[0], 1);

        // Short press: released 10 cycles after press_pulse.
        tick_to(24);
        btn_raw[0] = 1'b0;
        tick_to(34);
        check("short_n_rel", n_rel[0], 1);
        check("short_t_rel", t_rel[0], 30);
        check("short_no_long", n_long[0], 0);

        // Reset asserted mid-hold clears outputs immediately.
        btn_raw[0] = 1'b1;
        tick_to(45);
        check("midhold_level", btn_level, 2'b01);
        check("midhold_t_press", t_press[0], 40);
        rst_n = 1'b0;
        #1;
        check("midhold_rst_clear", {btn_level, press_pulse, release_pulse, long_pulse,
                                    repeat_pulse, any_press}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        clear_log();
        tick_to(8);
        check("post_rst_n_press", n_press[0], 1);
        check("post_rst_t_press", t_press[0], 6);
        btn_raw[0] = 1'b0;
        tick_to(20);
        check("post_rst_t_rel", t_rel[0], 14);

        // Long press on ch1, held 30 cycles after press_pulse.
        clear_log();
        btn_raw[1] = 1'b1;
        tick_to(36);
        btn_raw[1] = 1'b0;
        tick_to(50);
        check("long_t_press", t_press[1], 6);
        check("long_n_long", n_long[1], 1);
        check("long_t_long", t_long[1], 26);
        check("long_n_rel", n_rel[1], 1);
        check("long_t_rel", t_rel[1], 42);
        check("long_ch0_quiet", n_press[0] + n_long[0], 0);
`ifdef AUTOREPEAT_EN
        check("long_n_rpt", n_rpt[1], 3);
`else
        check("long_n_rpt", n_rpt[1], 0);
`endif

        // Auto-repeat on ch0.
        clear_log();
        btn_raw[0] = 1'b1;
        tick_to(46);
        check("rpt_t_long", t_long[0], 26);
`ifdef AUTOREPEAT_EN
        check("rpt_first", t_rpt1[0], 31);
        check("rpt_n_at46", n_rpt[0], 4);
        check("rpt_last_at46", t_rpt[0], 46);
`else
        check("rpt_n_at46", n_rpt[0], 0);
`endif
        btn_raw[0] = 1'b0;
        tick_to(60);
        check("rpt_n_long", n_long[0], 1);
        check("rpt_t_rel", t_rel[0], 52);
        check("rpt_n_rel", n_rel[0], 1);
`ifdef AUTOREPEAT_EN
        check("rpt_n_total", n_rpt[0], 5);
`else
        check("rpt_n_total", n_rpt[0], 0);
`endif
        check("rpt_idle_out", repeat_pulse, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
